// File: rtl/adc_block_avg.sv
// Dual-channel ADC block averager: discards settle samples, sums 2^n pairs, publishes rounded averages.
// Optional `ADC_PEAK_EN adds per-channel peak |sample| outputs captured over the accumulated samples.
module adc_block_avg #(
  parameter int ADC_WIDTH      = 12,
  parameter int LOG2_N_MAX     = 8,
  parameter int SETTLE_SAMPLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 adc_valid,
  input  logic [ADC_WIDTH-1:0] adc_a,
  input  logic [ADC_WIDTH-1:0] adc_b,
  input  logic                 start,
  input  logic                 abort,
  input  logic [3:0]           log2_n,
  input  logic                 clear_ovr,
  output logic                 busy,
  output logic                 done,
  output logic                 result_valid,
  output logic [ADC_WIDTH-1:0] avg_a,
  output logic [ADC_WIDTH-1:0] avg_b,
  output logic                 overrun
`ifdef ADC_PEAK_EN
  ,
  output logic [ADC_WIDTH-1:0] peak_a,
  output logic [ADC_WIDTH-1:0] peak_b
`endif
);

  localparam int ACC_WIDTH = ADC_WIDTH + LOG2_N_MAX;
  localparam int CNT_W     = LOG2_N_MAX + 1;
  localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE_SAMPLES);

  typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, OUTPUT} state_t;

  state_t                      state, state_nx;
  logic [3:0]                  n_lat;
  logic [3:0]                  n_clamp;
  logic [CNT_W-1:0]            cnt;
  logic [CNT_W-1:0]            cnt_inc;
  logic [CNT_W-1:0]            target;
  logic signed [ACC_WIDTH-1:0] acc_a, acc_b;
  logic signed [ACC_WIDTH-1:0] rnd;
  logic                        ovr_set;

  assign n_clamp = (log2_n > 4'(LOG2_N_MAX)) ? 4'(LOG2_N_MAX) : log2_n;
  assign cnt_inc = cnt + 1'b1;
  assign target  = CNT_W'(1) << n_lat;
  assign busy    = (state != IDLE);
  assign ovr_set = adc_valid && (state == OUTPUT);
  // Half an LSB of the result, so the arithmetic shift rounds half toward +inf.
  assign rnd     = (n_lat == 4'd0) ? '0 : (ACC_WIDTH'(1) << (n_lat - 4'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (start) state_nx = (SETTLE_SAMPLES == 0) ? ACCUM : SETTLE;
      SETTLE: if (abort) state_nx = IDLE;
              else if (adc_valid && cnt_inc == SETTLE_CNT) state_nx = ACCUM;
      ACCUM:  if (abort) state_nx = IDLE;
              else if (adc_valid && cnt_inc == target) state_nx = OUTPUT;
      OUTPUT: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

`ifdef ADC_PEAK_EN
  logic [ADC_WIDTH-1:0] pk_a, pk_b;
  logic [ADC_WIDTH-1:0] abs_a, abs_b;

  // The most negative code has no positive twin; it saturates to the largest positive code.
  function automatic logic [ADC_WIDTH-1:0] abs_sat(input logic [ADC_WIDTH-1:0] s);
    logic [ADC_WIDTH-1:0] m;
    m = s[ADC_WIDTH-1] ? (~s + 1'b1) : s;
    if (m[ADC_WIDTH-1]) m = {1'b0, {(ADC_WIDTH-1){1'b1}}};
    return m;
  endfunction

  assign abs_a = abs_sat(adc_a);
  assign abs_b = abs_sat(adc_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pk_a   <= '0;
      pk_b   <= '0;
      peak_a <= '0;
      peak_b <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          pk_a <= '0;
          pk_b <= '0;
        end
        ACCUM: if (!abort && adc_valid) begin
          if (abs_a > pk_a) pk_a <= abs_a;
          if (abs_b > pk_b) pk_b <= abs_b;
        end
        OUTPUT: if (!abort) begin
          peak_a <= pk_a;
          peak_b <= pk_b;
        end
        default: ;
      endcase
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_lat        <= '0;
      cnt          <= '0;
      acc_a        <= '0;
      acc_b        <= '0;
      done         <= 1'b0;
      result_valid <= 1'b0;
      avg_a        <= '0;
      avg_b        <= '0;
      overrun      <= 1'b0;
    end else begin
      done    <= 1'b0;
      overrun <= ovr_set | (overrun & ~clear_ovr);
      case (state)
        IDLE: if (start) begin
          n_lat        <= n_clamp;
          cnt          <= '0;
          acc_a        <= '0;
          acc_b        <= '0;
          result_valid <= 1'b0;
        end
        SETTLE: if (!abort && adc_valid) begin
          cnt <= (cnt_inc == SETTLE_CNT) ? '0 : cnt_inc;
        end
        ACCUM: if (!abort && adc_valid) begin
          acc_a <= acc_a + $signed({{LOG2_N_MAX{adc_a[ADC_WIDTH-1]}}, adc_a});
          acc_b <= acc_b + $signed({{LOG2_N_MAX{adc_b[ADC_WIDTH-1]}}, adc_b});
          cnt   <= cnt_inc;
        end
        OUTPUT: if (!abort) begin
          avg_a        <= ADC_WIDTH'((acc_a + rnd) >>> n_lat);
          avg_b        <= ADC_WIDTH'((acc_b + rnd) >>> n_lat);
          done         <= 1'b1;
          result_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
